truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Parameters
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of cycles each input vector is held before Y is sampled (legal range 1..15).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to run one full 8-vector sweep.
REQ-005 The block SHALL have port Y_in, input, 1 bit: output of the external circuit under test, Y = (~C & D) | (B & D).
REQ-006 The block SHALL have ports B, C, D, each an output of 1 bit: the stimulus vector driven to the circuit under test.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-009 The block SHALL have port pass, output, 1 bit: high when the last completed sweep had zero mismatches.
REQ-010 The block SHALL have port result, output, 8 bits: captured Y; bit i holds Y for vector {B,C,D} = i.
REQ-011 The block SHALL have port mismatch, output, 8 bits: bit i is set when captured Y differs from expected Y for vector i.
REQ-012 The block SHALL have port err_cnt, output, 4 bits: number of mismatching vectors in the sweep, 0..8.

Function
REQ-013 The FSM SHALL have the states IDLE, APPLY, SAMPLE and DONE; encoding is free.
REQ-014 In IDLE, start=1 at a rising edge SHALL do all of the following at that edge: load the vector index to 0, clear result, mismatch and err_cnt, and enter APPLY.
REQ-015 In APPLY, the index SHALL be driven on {B,C,D} (B = MSB), and the state SHALL be held for exactly SETTLE cycles using a 4-bit settle counter, then move to SAMPLE.
REQ-016 In SAMPLE, the block SHALL do all of the following within one cycle: capture Y_in into result[idx], compute expected = D & (~C | B) from the current index, set mismatch[idx] on inequality, and increment err_cnt on inequality.
REQ-017 From SAMPLE, an index below 7 SHALL increment the index and return to APPLY; an index of 7 SHALL move to DONE without wrapping the index.
REQ-018 DONE SHALL last exactly one cycle with done=1 and busy=0, update pass to (err_cnt==0) including the final vector's contribution, then return to IDLE.
REQ-019 busy SHALL be 1 in APPLY and SAMPLE and 0 in IDLE and DONE.
REQ-020 With start sampled at edge k, done SHALL be high in the cycle after edge k + 8*(SETTLE+1).
REQ-021 start SHALL be ignored in APPLY, SAMPLE and DONE; no queuing or restart is allowed.
REQ-022 A start held high continuously SHALL re-launch a sweep from IDLE on the edge after DONE.
REQ-023 {B,C,D} SHALL hold the last applied vector (3'b111) in DONE and IDLE until the next sweep begins.
REQ-024 result, mismatch, err_cnt and pass SHALL hold their values between sweeps and change only during a sweep or on reset.
REQ-025 err_cnt SHALL saturate-free count to at most 8 and never wrap.

Reset
REQ-026 rst_n=0 SHALL take effect immediately regardless of clk, and set the state to IDLE, the index and settle counter to 0, and B, C, D, busy, done, pass, result, mismatch and err_cnt to 0.
REQ-027 A reset asserted mid-sweep SHALL abort the sweep with no done pulse, and the partial results SHALL be discarded (cleared).
REQ-028 After rst_n deasserts, the block SHALL wait in IDLE for a fresh start.

Verification
REQ-029 With a correct circuit and SETTLE=1, a start pulse SHALL produce: result=8'hA2, mismatch=8'h00, err_cnt=0, pass=1, and done 16 cycles after the start edge.
REQ-030 With Y_in stuck at 0, the sweep SHALL produce: result=8'h00, mismatch=8'hA2, err_cnt=3, pass=0.
REQ-031 With Y_in stuck at 1, the sweep SHALL produce: result=8'hFF, mismatch=8'h5D, err_cnt=5, pass=0.
REQ-032 With SETTLE=3, {B,C,D} SHALL step 000→111, with each vector held 3 cycles plus one SAMPLE cycle, and done SHALL occur 32 cycles after start.
REQ-033 When rst_n is pulsed low during vector 4, all outputs SHALL go to 0 asynchronously with no done pulse, and a following start SHALL yield a clean full sweep.
REQ-034 Start pulses applied while busy=1 SHALL be ignored, and exactly one done pulse SHALL occur per accepted start.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps {B,C,D} over 0..7, samples Y_in and scores it against D & (~C | B)
// Ports: clk, rst_n (async, active low), start, Y_in -> B, C, D, busy, done, pass, result[7:0], mismatch[7:0], err_cnt[3:0]
module truth_table_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Y_in,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [7:0] mismatch,
  output logic [3:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  state_t     state_q;
  logic [2:0] idx_q;
  logic [3:0] settle_q;
  logic       busy_q, done_q, pass_q;
  logic [7:0] result_q, mismatch_q;
  logic [3:0] err_q;
  logic       exp_y, miss_d;
  logic [3:0] err_d;
  assign exp_y  = idx_q[0] & (~idx_q[1] | idx_q[2]);
  assign miss_d = Y_in != exp_y;
  assign err_d  = err_q + {3'b0, miss_d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      result_q   <= '0;
      mismatch_q <= '0;
      err_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          idx_q      <= '0;
          settle_q   <= '0;
          result_q   <= '0;
          mismatch_q <= '0;
          err_q      <= '0;
          busy_q     <= 1'b1;
          state_q    <= APPLY;
        end
        APPLY: if (settle_q == SETTLE_M1) begin
          settle_q <= '0;
          state_q  <= SAMPLE;
        end else begin
          settle_q <= settle_q + 4'd1;
        end
        SAMPLE: begin
          result_q[idx_q]   <= Y_in;
          mismatch_q[idx_q] <= miss_d;
          err_q             <= err_d;
          if (idx_q == 3'd7) begin
            // pass must include the last vector, so use the updated count
            pass_q  <= err_d == 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= APPLY;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {B, C, D} = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign result    = result_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: drives SETTLE=1 and SETTLE=3 sequencers against a faultable model circuit
module tb_truth_table_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] g = '0, flip = '0;
  logic b1, c1, d1, busy1, done1, pass1, b3, c3, d3, busy3, done3, pass3;
  logic [7:0] res1, mis1, res3, mis3;
  logic [3:0] err1, err3;
  logic y1, y3;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  assign y1 = g[{b1, c1, d1}] ^ flip[{b1, c1, d1}];
  assign y3 = g[{b3, c3, d3}] ^ flip[{b3, c3, d3}];
  truth_table_sequencer #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start), .Y_in(y1),
    .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1), .pass(pass1),
    .result(res1), .mismatch(mis1), .err_cnt(err1));
  truth_table_sequencer #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .start(start), .Y_in(y3),
    .B(b3), .C(c3), .D(d3), .busy(busy3), .done(done3), .pass(pass3),
    .result(res3), .mismatch(mis3), .err_cnt(err3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic launch();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask
  task automatic sweep(input logic [7:0] f, input bit noise);
    int n1, n3, t1, t3;
    n1 = 0; n3 = 0; t1 = -1; t3 = -1;
    flip = f;
    launch();
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      start = (noise && n < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done1) begin n1++; t1 = n; end
      if (done3) begin n3++; t3 = n; end
      if (n <= 16) begin
        chk("vec_s1", 32'({b1, c1, d1}), 32'(n < 16 ? n / 2 : 7));
        chk("busy_s1", 32'(busy1), 32'(n < 16));
      end
      if (n <= 32) begin
        chk("vec_s3", 32'({b3, c3, d3}), 32'(n < 32 ? n / 4 : 7));
        chk("busy_s3", 32'(busy3), 32'(n < 32));
      end
    end
    start = 1'b0;
    chk("done_cnt_s1", 32'(n1), 1);
    chk("done_at_s1", 32'(t1), 16);
    chk("done_cnt_s3", 32'(n3), 1);
    chk("done_at_s3", 32'(t3), 32);
    chk("result_s1", 32'(res1), 32'(g ^ f));
    chk("mismatch_s1", 32'(mis1), 32'(f));
    chk("err_cnt_s1", 32'(err1), 32'($countones(f)));
    chk("pass_s1", 32'(pass1), 32'(f == 8'h00));
    chk("result_s3", 32'(res3), 32'(g ^ f));
    chk("mismatch_s3", 32'(mis3), 32'(f));
    chk("err_cnt_s3", 32'(err3), 32'($countones(f)));
    chk("pass_s3", 32'(pass3), 32'(f == 8'h00));
  endtask
  function automatic logic [31:0] all1();
    return 32'({b1, c1, d1, busy1, done1, pass1, res1, mis1, err1} != 0);
  endfunction
  function automatic logic [31:0] all3();
    return 32'({b3, c3, d3, busy3, done3, pass3, res3, mis3, err3} != 0);
  endfunction
  initial begin
    int dn;
    for (int i = 0; i < 8; i++) begin
      logic bb, cc, dd;
      {bb, cc, dd} = 3'(i);
      g[i] = (~cc & dd) | (bb & dd);
    end
    #12;
    chk("reset_s1", all1(), 0);
    chk("reset_s3", all3(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_after_reset", 32'(busy1 | busy3), 0);
    chk("golden_table", 32'(g), 32'h A2);
    sweep(8'h00, 1'b0);
    sweep(g, 1'b0);
    sweep(~g, 1'b1);
    for (int r = 0; r < 3; r++) sweep(8'($urandom), 1'b1);
    flip = 8'($urandom);
    launch();
    repeat (8) @(posedge clk);
    #1 chk("mid_vec_s1", 32'({b1, c1, d1}), 4);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_s1", all1(), 0);
    chk("async_rst_s3", all3(), 0);
    dn = 0;
    repeat (4) begin @(posedge clk); #1 dn += int'(done1) + int'(done3); end
    chk("no_done_on_abort", 32'(dn), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1 dn += int'(busy1) + int'(busy3); end
    chk("wait_for_start", 32'(dn), 0);
    sweep(8'h00, 1'b0);
    flip = 8'h00;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1 chk("held_idle_s1", 32'(busy1), 0);
    @(posedge clk);
    #1 chk("held_relaunch_s1", 32'({busy1, b1, c1, d1}), 32'h8);
    start = 1'b0;
    rst_n = 1'b0;
    #10 rst_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
